// File: rtl/uart_pkg.sv
// Shared UART definitions: autobaud FSM encoding and the 9600-baud
// divider defaults also used by the receiver.
package uart_pkg;

    // Autobaud calibration states
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_MEASURE = 3'd2,
        S_CONFIRM = 3'd3,
        S_LOCKED  = 3'd4
    } ab_state_t;

    // 9600 baud at the system clock: full-bit and half-bit compare values
    localparam int unsigned DEF_BAUD_DIV = 32'd1042;
    localparam int unsigned DEF_HALF_DIV = 32'd521;

endpackage

// File: rtl/uart_sync_edge.sv
// Two-flop synchronizer for an asynchronous serial line, plus a delayed
// copy used to flag rising and falling edges of the synchronized level.
module uart_sync_edge (
    input  logic clk,
    input  logic rst_,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_r;
    logic sync_r;
    logic prev_r;

    // Synchronizer chain and previous-value register; idle line is high
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
            prev_r <= 1'b1;
        end else begin
            meta_r <= din;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign level = sync_r;
    assign rise  = sync_r & ~prev_r;
    assign fall  = ~sync_r & prev_r;

endmodule

// File: rtl/uart_autobaud_ctrl.sv
// Autobaud controller: times the eight bit intervals of a 0x55 sync
// character, confirms the stop-bit edge, and publishes rounded full-bit
// and half-bit divider values for the UART receiver.
module uart_autobaud_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned MIN_BIT      = 16,
    parameter int unsigned MAX_BIT      = 65535,
    parameter int unsigned IDLE_MIN     = 4096,
    parameter int unsigned DEF_BAUD_DIV = uart_pkg::DEF_BAUD_DIV,
    parameter int unsigned DEF_HALF_DIV = uart_pkg::DEF_HALF_DIV
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             Din,
    input  logic             start,
    output logic [CNT_W-1:0] baud_div,
    output logic [CNT_W-1:0] half_div,
    output logic             locked,
    output logic             err
);

    localparam int unsigned SUM_W = CNT_W + 3;

    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_MIN - 32'd1);
    localparam logic [CNT_W-1:0] MIN_IVL   = CNT_W'(MIN_BIT);
    localparam logic [CNT_W-1:0] MAX_LAST  = CNT_W'(MAX_BIT - 32'd1);
    localparam logic [SUM_W-1:0] SUM_RND   = {{(SUM_W-3){1'b0}}, 3'b100};

    // Round-half-up average of eight intervals: (sum + 4) / 8
    function automatic logic [CNT_W-1:0] round_period(input logic [SUM_W-1:0] sum);
        logic [SUM_W-1:0] biased;
        biased = sum + SUM_RND;
        return biased[SUM_W-1:3];
    endfunction

    logic             level_s;
    logic             rise_s;
    logic             fall_s;
    logic             edge_s;
    logic [CNT_W-1:0] ivl_s;
    logic [CNT_W-1:0] div_s;

    ab_state_t        state_r,    nxt_state_s;
    logic [CNT_W-1:0] cnt_r,      nxt_cnt_s;
    logic [3:0]       edge_cnt_r, nxt_edge_cnt_s;
    logic [SUM_W-1:0] sum_r,      nxt_sum_s;
    logic [CNT_W-1:0] baud_div_r, nxt_baud_div_s;
    logic [CNT_W-1:0] half_div_r, nxt_half_div_s;
    logic             locked_r,   nxt_locked_s;
    logic             err_r,      nxt_err_s;

    uart_sync_edge u_sync (
        .clk   (clk),
        .rst_  (rst_),
        .din   (Din),
        .level (level_s),
        .rise  (rise_s),
        .fall  (fall_s)
    );

    assign edge_s = rise_s | fall_s;
    assign ivl_s  = cnt_r + CNT_ONE;
    assign div_s  = round_period(sum_r) - CNT_ONE;

    // Calibration sequencing, interval accumulation and result publication
    always_comb begin
        nxt_state_s    = state_r;
        nxt_cnt_s      = cnt_r;
        nxt_edge_cnt_s = edge_cnt_r;
        nxt_sum_s      = sum_r;
        nxt_baud_div_s = baud_div_r;
        nxt_half_div_s = half_div_r;
        nxt_locked_s   = locked_r;
        nxt_err_s      = 1'b0;

        if (start) begin
            // Start outranks any edge or timeout: drop lock, recount idle
            nxt_state_s  = S_IDLE;
            nxt_cnt_s    = '0;
            nxt_locked_s = 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (!level_s) begin
                        nxt_cnt_s = '0;
                    end else if (cnt_r == IDLE_LAST) begin
                        nxt_state_s = S_ARMED;
                        nxt_cnt_s   = '0;
                    end else begin
                        nxt_cnt_s = cnt_r + CNT_ONE;
                    end
                end
                S_ARMED: begin
                    if (fall_s) begin
                        nxt_state_s    = S_MEASURE;
                        nxt_cnt_s      = '0;
                        nxt_edge_cnt_s = 4'd0;
                        nxt_sum_s      = '0;
                    end else begin
                        nxt_state_s = S_ARMED;
                    end
                end
                S_MEASURE: begin
                    if (edge_s) begin
                        if (ivl_s < MIN_IVL) begin
                            nxt_err_s   = 1'b1;
                            nxt_state_s = S_IDLE;
                            nxt_cnt_s   = '0;
                        end else begin
                            nxt_sum_s      = sum_r + {3'b000, ivl_s};
                            nxt_edge_cnt_s = edge_cnt_r + 4'd1;
                            nxt_cnt_s      = '0;
                            // Eighth edge is the fall opening bit7
                            if (edge_cnt_r == 4'd7) begin
                                nxt_state_s = S_CONFIRM;
                            end else begin
                                nxt_state_s = S_MEASURE;
                            end
                        end
                    end else if (cnt_r >= MAX_LAST) begin
                        nxt_err_s   = 1'b1;
                        nxt_state_s = S_IDLE;
                        nxt_cnt_s   = '0;
                    end else begin
                        nxt_cnt_s = cnt_r + CNT_ONE;
                    end
                end
                S_CONFIRM: begin
                    if (edge_s) begin
                        if (ivl_s < MIN_IVL) begin
                            nxt_err_s   = 1'b1;
                            nxt_state_s = S_IDLE;
                            nxt_cnt_s   = '0;
                        end else begin
                            nxt_baud_div_s = div_s;
                            nxt_half_div_s = {1'b0, div_s[CNT_W-1:1]};
                            nxt_locked_s   = 1'b1;
                            nxt_state_s    = S_LOCKED;
                            nxt_cnt_s      = '0;
                        end
                    end else if (cnt_r >= MAX_LAST) begin
                        nxt_err_s   = 1'b1;
                        nxt_state_s = S_IDLE;
                        nxt_cnt_s   = '0;
                    end else begin
                        nxt_cnt_s = cnt_r + CNT_ONE;
                    end
                end
                S_LOCKED: begin
                    nxt_state_s = S_LOCKED;
                end
                default: begin
                    nxt_state_s = S_IDLE;
                    nxt_cnt_s   = '0;
                end
            endcase
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_r    <= S_IDLE;
            cnt_r      <= '0;
            edge_cnt_r <= 4'd0;
            sum_r      <= '0;
            baud_div_r <= CNT_W'(DEF_BAUD_DIV);
            half_div_r <= CNT_W'(DEF_HALF_DIV);
            locked_r   <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= nxt_state_s;
            cnt_r      <= nxt_cnt_s;
            edge_cnt_r <= nxt_edge_cnt_s;
            sum_r      <= nxt_sum_s;
            baud_div_r <= nxt_baud_div_s;
            half_div_r <= nxt_half_div_s;
            locked_r   <= nxt_locked_s;
            err_r      <= nxt_err_s;
        end
    end

    assign baud_div = baud_div_r;
    assign half_div = half_div_r;
    assign locked   = locked_r;
    assign err      = err_r;

endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
// Self-checking bench for uart_autobaud_ctrl: calibrations at several bit
// rates, glitch and timeout errors, start/abort handling and mid-frame reset.
module tb_uart_autobaud_ctrl;

    localparam int MAX_BIT = 2000;

    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic        Din = 1'b1;
    logic        start = 1'b0;
    logic [15:0] baud_div;
    logic [15:0] half_div;
    logic        locked;
    logic        err;

    int n_checks = 0;
    int n_pass   = 0;

    int   err_pulses = 0;
    int   err_wide   = 0;
    logic err_q      = 1'b0;

    typedef struct {
        logic [15:0] baud;
        logic [15:0] half;
    } exp_t;
    exp_t sb_q[$];

    uart_autobaud_ctrl #(
        .CNT_W   (16),
        .MIN_BIT (16),
        .MAX_BIT (MAX_BIT),
        .IDLE_MIN(4096)
    ) dut (
        .clk     (clk),
        .rst_    (rst_),
        .Din     (Din),
        .start   (start),
        .baud_div(baud_div),
        .half_div(half_div),
        .locked  (locked),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Count err pulses and flag any pulse longer than one cycle
    always @(negedge clk) begin
        if (err === 1'b1) err_pulses <= err_pulses + 1;
        if (err === 1'b1 && err_q) err_wide <= err_wide + 1;
        err_q <= (err === 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // 0x55 frame: start,b0..b7 alternate low/high; even bits last d_even
    task automatic send_frame(input int d_even, input int d_odd);
        for (int i = 0; i < 9; i++) begin
            Din = (i % 2 == 1);
            ticks((i % 2 == 0) ? d_even : d_odd);
        end
        Din = 1'b1;
    endtask

    task automatic test_reset();
        rst_ = 1'b0; Din = 1'b1; start = 1'b0;
        ticks(3);
        rst_ = 1'b1;
        tick();
        n_checks++; if (baud_div !== 16'd1042) $display("FAIL reset_baud got %0d expected 1042", baud_div); else n_pass++;
        n_checks++; if (half_div !== 16'd521) $display("FAIL reset_half got %0d expected 521", half_div); else n_pass++;
        n_checks++; if (locked !== 1'b0) $display("FAIL reset_locked got %b expected 0", locked); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL reset_err got %b expected 0", err); else n_pass++;
    endtask

    task automatic test_glitch();
        int e0, w0;
        ticks(4200);
        e0 = err_pulses; w0 = err_wide;
        Din = 1'b0;
        ticks(3);
        Din = 1'b1;
        ticks(20);
        n_checks++; if (err_pulses - e0 !== 1) $display("FAIL glitch_err_count got %0d expected 1", err_pulses - e0); else n_pass++;
        n_checks++; if (err_wide - w0 !== 0) $display("FAIL glitch_err_width got %0d long pulses expected 0", err_wide - w0); else n_pass++;
        n_checks++; if (locked !== 1'b0) $display("FAIL glitch_locked got %b expected 0", locked); else n_pass++;
        n_checks++; if (baud_div !== 16'd1042) $display("FAIL glitch_baud got %0d expected 1042", baud_div); else n_pass++;
    endtask

    task automatic test_cal(input int d_even, input int d_odd);
        exp_t e;
        int   sum, period, e0;
        ticks(4200);
        // First eight bit intervals: four of each length
        sum    = 4 * d_even + 4 * d_odd;
        period = (sum + 4) / 8;
        e.baud = 16'(period - 1);
        e.half = 16'((period - 1) / 2);
        sb_q.push_back(e);
        e0 = err_pulses;
        send_frame(d_even, d_odd);
        // Two synchronizer cycles, then the detection edge publishes results
        ticks(2);
        n_checks++; if (locked !== 1'b0) $display("FAIL cal%0d_early_lock got %b expected 0", d_even, locked); else n_pass++;
        tick();
        n_checks++; if (locked !== 1'b1) $display("FAIL cal%0d_locked got %b expected 1", d_even, locked); else n_pass++;
        n_checks++;
        if (sb_q.size() == 0) begin
            $display("FAIL cal%0d_scoreboard empty queue", d_even);
        end else begin
            n_pass++;
            e = sb_q.pop_front();
            n_checks++; if (baud_div !== e.baud) $display("FAIL cal%0d_baud got %0d expected %0d", d_even, baud_div, e.baud); else n_pass++;
            n_checks++; if (half_div !== e.half) $display("FAIL cal%0d_half got %0d expected %0d", d_even, half_div, e.half); else n_pass++;
        end
        n_checks++; if (err_pulses !== e0) $display("FAIL cal%0d_no_err got %0d pulses expected 0", d_even, err_pulses - e0); else n_pass++;
    endtask

    task automatic test_unlock(input logic [15:0] exp_baud, input logic [15:0] exp_half);
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if (locked !== 1'b0) $display("FAIL unlock_locked got %b expected 0", locked); else n_pass++;
        n_checks++; if (baud_div !== exp_baud) $display("FAIL unlock_baud_held got %0d expected %0d", baud_div, exp_baud); else n_pass++;
        n_checks++; if (half_div !== exp_half) $display("FAIL unlock_half_held got %0d expected %0d", half_div, exp_half); else n_pass++;
    endtask

    task automatic test_timeout();
        int n, e0, w0;
        bit found;
        ticks(4200);
        e0 = err_pulses; w0 = err_wide;
        n = 0; found = 1'b0;
        Din = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            tick();
            n++;
            if (err === 1'b1) found = 1'b1;
        end
        // 2 synchronizer edges + detection edge + MAX_BIT counting cycles
        n_checks++; if (!found || n != MAX_BIT + 3) $display("FAIL timeout_latency got %0d cycles (seen=%0d) expected %0d", n, found, MAX_BIT + 3); else n_pass++;
        ticks(5);
        Din = 1'b1;
        ticks(5);
        n_checks++; if (err_pulses - e0 !== 1) $display("FAIL timeout_err_count got %0d expected 1", err_pulses - e0); else n_pass++;
        n_checks++; if (err_wide - w0 !== 0) $display("FAIL timeout_err_width got %0d expected 0", err_wide - w0); else n_pass++;
        n_checks++; if (baud_div !== 16'd100) $display("FAIL timeout_baud_held got %0d expected 100", baud_div); else n_pass++;
        n_checks++; if (locked !== 1'b0) $display("FAIL timeout_locked got %b expected 0", locked); else n_pass++;
    endtask

    task automatic test_abort();
        int e0;
        ticks(4200);
        e0 = err_pulses;
        Din = 1'b0;
        ticks(50);
        Din = 1'b1;
        ticks(30);
        start = 1'b1;
        tick();
        start = 1'b0;
        // Without the abort the stalled measurement would time out here
        ticks(2500);
        n_checks++; if (err_pulses !== e0) $display("FAIL abort_no_err got %0d pulses expected 0", err_pulses - e0); else n_pass++;
        n_checks++; if (locked !== 1'b0) $display("FAIL abort_locked got %b expected 0", locked); else n_pass++;
        n_checks++; if (baud_div !== 16'd100) $display("FAIL abort_baud_held got %0d expected 100", baud_div); else n_pass++;
    endtask

    task automatic test_reset_mid();
        ticks(4200);
        Din = 1'b0;
        ticks(200);
        Din = 1'b1;
        ticks(100);
        n_checks++; if (baud_div !== 16'd100) $display("FAIL midrst_pre_baud got %0d expected 100", baud_div); else n_pass++;
        rst_ = 1'b0;
        #1;
        n_checks++; if (baud_div !== 16'd1042) $display("FAIL midrst_baud got %0d expected 1042", baud_div); else n_pass++;
        n_checks++; if (half_div !== 16'd521) $display("FAIL midrst_half got %0d expected 521", half_div); else n_pass++;
        n_checks++; if (locked !== 1'b0) $display("FAIL midrst_locked got %b expected 0", locked); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL midrst_err got %b expected 0", err); else n_pass++;
        ticks(3);
        rst_ = 1'b1;
        ticks(2);
        n_checks++; if (baud_div !== 16'd1042) $display("FAIL midrst_after_baud got %0d expected 1042", baud_div); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_cal(1043, 1043);
        test_unlock(16'd1042, 16'd521);
        test_cal(104, 104);
        test_unlock(16'd103, 16'd51);
        test_cal(1043, 1043);
        test_unlock(16'd1042, 16'd521);
        test_cal(100, 101);
        test_unlock(16'd100, 16'd50);
        test_timeout();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Bound total runtime in case the DUT wedges
    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at %0t, %0d/%0d checks passed", $time, n_pass, n_checks);
        $fatal(1);
    end

endmodule
